cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_run_monitor.sv | 133 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Watches a CPU run: detects halt (pc stable), aborts on timeout, then checks
// masked watched registers against expected values and traces value changes.
module cpu_run_monitor #(
  parameter int XLEN        = 32,
  parameter int NCH         = 4,
  parameter int TIMEOUT     = 1024,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [XLEN-1:0]      pc,
  input  logic [NCH*XLEN-1:0]  watch_val,
  input  logic [NCH*XLEN-1:0]  expect_val,
  input  logic [NCH-1:0]       expect_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [XLEN-1:0]      halted_pc,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [NCH-1:0]       mismatch_vec,
  output logic                 trace_valid,
  output logic [NCH-1:0]       trace_mask
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | counting cycles, watching pc for a halt and watch_val for changes
  // CHECK | one cycle comparing watched values against expectations
  // DONE  | results held until the next start
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam int SW = $clog2(HALT_REPEAT + 1);
  localparam logic [SW-1:0]    HALT_AT = SW'(HALT_REPEAT - 2);
  localparam logic [CNT_W-1:0] TO_AT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (HALT_REPEAT < 2 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_param_check
    $error("cpu_run_monitor: need HALT_REPEAT >= 2 and TIMEOUT <= 2^CNT_W-1");
  end

  state_t              state;
  logic [XLEN-1:0]     prev_pc;
  logic [NCH*XLEN-1:0] prev_watch;
  logic [SW-1:0]       stable;
  logic [NCH-1:0]      diff;
  logic [NCH-1:0]      miss;
  logic [CNT_W-1:0]    cnt_next;
  logic                same_pc;
  logic                halt_hit;

  always_comb begin
    diff = '0;
    miss = '0;
    for (int i = 0; i < NCH; i++) begin
      diff[i] = watch_val[i*XLEN +: XLEN] != prev_watch[i*XLEN +: XLEN];
      miss[i] = expect_mask[i] & (watch_val[i*XLEN +: XLEN] != expect_val[i*XLEN +: XLEN]);
    end
    same_pc  = pc == prev_pc;
    halt_hit = same_pc && (stable == HALT_AT);
    cnt_next = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      halted_pc    <= '0;
      cycle_cnt    <= '0;
      mismatch_vec <= '0;
      trace_valid  <= 1'b0;
      trace_mask   <= '0;
      prev_pc      <= '0;
      prev_watch   <= '0;
      stable       <= '0;
    end else begin
      trace_valid <= 1'b0;
      trace_mask  <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            halted_pc    <= '0;
            cycle_cnt    <= '0;
            mismatch_vec <= '0;
            stable       <= '0;
            prev_pc      <= pc;
            prev_watch   <= watch_val;
          end
        end
        RUN: begin
          trace_mask  <= diff;
          trace_valid <= |diff;
          prev_watch  <= watch_val;
          prev_pc     <= pc;
          stable      <= same_pc ? SW'(stable + 1'b1) : '0;
          // A halt seen on the timeout cycle still wins.
          if (halt_hit) begin
            halted_pc <= pc;
            cycle_cnt <= cnt_next;
            state     <= CHECK;
          end else if (cycle_cnt == TO_AT) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cycle_cnt <= cnt_next;
          end
        end
        CHECK: begin
          mismatch_vec <= miss;
          pass         <= ~|miss;
          busy         <= 1'b0;
          done         <= 1'b1;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized and directed bench for cpu_run_monitor with a sample-window
// reference model checked against the DUT every cycle.
module tb_cpu_run_monitor;
  localparam int XLEN = 32;
  localparam int NCH  = 4;
  localparam int TO   = 16;
  localparam int HR   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [XLEN-1:0]     pc = '0;
  logic [NCH*XLEN-1:0] watch_val = '0;
  logic [NCH*XLEN-1:0] expect_val = '0;
  logic [NCH-1:0]      expect_mask = '0;
  logic                busy, done, pass, timeout, trace_valid;
  logic [XLEN-1:0]     halted_pc;
  logic [CW-1:0]       cycle_cnt;
  logic [NCH-1:0]      mismatch_vec, trace_mask;

  cpu_run_monitor #(.XLEN(XLEN), .NCH(NCH), .TIMEOUT(TO), .HALT_REPEAT(HR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .watch_val(watch_val),
    .expect_val(expect_val), .expect_mask(expect_mask), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .halted_pc(halted_pc), .cycle_cnt(cycle_cnt),
    .mismatch_vec(mismatch_vec), .trace_valid(trace_valid), .trace_mask(trace_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ch(input logic [NCH*XLEN-1:0] v, input int i);
    return v[i*XLEN +: XLEN];
  endfunction

  // Reference model: 0 idle, 1 run, 2 check, 3 done
  int              m_state = 0;
  int              m_cnt = 0;
  bit              m_pass = 0, m_to = 0, m_tv = 0;
  logic [XLEN-1:0] m_hpc = '0;
  logic [NCH-1:0]  m_mm = '0, m_tm = '0;
  logic [XLEN-1:0] m_prev_w [NCH];
  logic [XLEN-1:0] pcs [$];

  always @(posedge clk) begin
    logic [NCH-1:0] tm, mm;
    bit halt;
    tm = '0;
    mm = '0;
    halt = 0;
    if (!reset) begin
      m_state = 0; m_cnt = 0; m_pass = 0; m_to = 0; m_hpc = '0;
      m_mm = '0; m_tv = 0; m_tm = '0;
      pcs.delete();
    end else begin
      case (m_state)
        0, 3: if (start) begin
          m_state = 1; m_cnt = 0; m_pass = 0; m_to = 0; m_hpc = '0; m_mm = '0;
          pcs.delete();
          pcs.push_back(pc);
          for (int i = 0; i < NCH; i++) m_prev_w[i] = ch(watch_val, i);
        end
        1: begin
          for (int i = 0; i < NCH; i++) begin
            tm[i] = ch(watch_val, i) != m_prev_w[i];
            m_prev_w[i] = ch(watch_val, i);
          end
          pcs.push_back(pc);
          if (pcs.size() > HR) void'(pcs.pop_front());
          halt = (pcs.size() == HR);
          foreach (pcs[j]) if (pcs[j] != pcs[0]) halt = 0;
          if (halt) begin
            m_hpc = pc;
            m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_state = 2;
          end else if (m_cnt == TO - 1) begin
            m_to = 1; m_pass = 0; m_state = 3;
          end else begin
            m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          end
        end
        2: begin
          for (int i = 0; i < NCH; i++)
            mm[i] = expect_mask[i] && (ch(watch_val, i) != ch(expect_val, i));
          m_mm = mm;
          m_pass = (mm == '0);
          m_state = 3;
        end
        default: m_state = 0;
      endcase
      m_tv = |tm;
      m_tm = tm;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_state == 1 || m_state == 2));
      chk("done", done, (m_state == 3));
      chk("pass", pass, m_pass);
      chk("timeout", timeout, m_to);
      chk("halted_pc", halted_pc, m_hpc);
      chk("cycle_cnt", cycle_cnt, 64'(m_cnt));
      chk("mismatch_vec", mismatch_vec, m_mm);
      chk("trace_valid", trace_valid, m_tv);
      chk("trace_mask", trace_mask, m_tm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [XLEN-1:0] v);
    watch_val[i*XLEN +: XLEN] = v;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic pc_ramp_run();
    pc = 0;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 10; k++) begin
      pc = 4 * k;
      tick();
    end
    wait_done();
  endtask

  initial begin
    int npulse, nrun;
    logic [NCH-1:0] tm_seen;

    repeat (3) tick();
    chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_trace", trace_valid, 0);
    reset = 1;
    tick();

    // pc ramps to 40 then holds; ch0 matches
    expect_mask = 4'b0001;
    expect_val[0 +: XLEN] = 55;
    set_ch(0, 55);
    pc_ramp_run();
    chk("a_pass", pass, 1);
    chk("a_timeout", timeout, 0);
    chk("a_hpc", halted_pc, 40);
    chk("a_mm", mismatch_vec, 0);
    chk("a_cnt", cycle_cnt, 13);

    // same, ch0 mismatching
    set_ch(0, 54);
    pc_ramp_run();
    chk("b_pass", pass, 0);
    chk("b_mm", mismatch_vec, 4'b0001);

    // single trace pulse on ch2
    set_ch(0, 55);
    set_ch(2, 0);
    expect_mask = 0;
    pc = 100;
    start = 1;
    tick();
    start = 0;
    npulse = 0;
    tm_seen = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k == 2) set_ch(2, 7);
      if (k < 5) pc = 101 + k;
      tick();
      if (trace_valid) begin
        npulse++;
        tm_seen = trace_mask;
      end
    end
    chk("c_pulses", npulse, 1);
    chk("c_mask", tm_seen, 4'b0100);
    chk("c_done", done, 1);

    // timeout: pc never settles
    pc = 0;
    start = 1;
    tick();
    start = 0;
    nrun = 0;
    while (!done && nrun < 100) begin
      pc = pc + 1;
      tick();
      nrun++;
    end
    chk("d_runcyc", nrun, 16);
    chk("d_timeout", timeout, 1);
    chk("d_pass", pass, 0);
    chk("d_cnt", cycle_cnt, 15);

    // reset mid-run with start held
    start = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      pc = pc + 1;
      tick();
    end
    reset = 0;
    tick();
    chk("e_busy", busy, 0);
    chk("e_done", done, 0);
    chk("e_cnt", cycle_cnt, 0);
    chk("e_timeout", timeout, 0);
    reset = 1;
    start = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    chk("e_restart_busy", busy, 1);
    chk("e_restart_cnt", cycle_cnt, 0);
    wait_done();

    // restart from DONE with nothing masked
    expect_mask = 0;
    for (int i = 0; i < NCH; i++) set_ch(i, $urandom_range(0, 3));
    start = 1;
    tick();
    start = 0;
    chk("f_done_drop", done, 0);
    wait_done();
    chk("f_pass", pass, 1);

    // randomized traffic checked by the model
    for (int k = 0; k < 2500; k++) begin
      reset = ($urandom_range(0, 59) != 0);
      start = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: pc = $urandom_range(0, 2) * 4;
        1: pc = pc + 4;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) set_ch($urandom_range(0, NCH - 1), $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        expect_mask = NCH'($urandom);
        for (int i = 0; i < NCH; i++) expect_val[i*XLEN +: XLEN] = $urandom_range(0, 3);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
